// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage sequencer and the hazard unit.
package pc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_HALT  = 3'd4
    } seq_state_t;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int PC_INC         = 2;

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage next-address controller: sequential, redirect, stall and halt
// selection plus IF/ID, ID/EX control and a saturating redirect counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(16'h00F0),
    parameter int                STALL_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              stall_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              exception,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] next_address,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              halted,
    output logic [15:0]       redirect_count
);

    seq_state_t state, next_state;
    logic [7:0] stall_cnt;
    logic       watchdog_fire;
    logic       exc_req;
    logic       redirect;
    logic       in_flow;

    assign watchdog_fire = (state == ST_STALL) && (stall_cnt == 8'(STALL_LIMIT));
    assign exc_req       = exception || watchdog_fire;
    assign in_flow       = (state == ST_RUN) || (state == ST_STALL) || (state == ST_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RESET;
            idex_flush <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= next_state;
            idex_flush <= (next_state == ST_FLUSH);
            halted     <= (next_state == ST_HALT);
        end
    end

    always_comb begin
        next_state   = state;
        next_address = address;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        redirect     = 1'b0;
        case (state)
            ST_RESET: begin
                next_address = RESET_VECTOR;
                pc_write     = 1'b1;
                ifid_flush   = 1'b1;
                next_state   = ST_RUN;
            end
            ST_HALT: begin
                if (exception) begin
                    next_address = EXC_VECTOR;
                    pc_write     = 1'b1;
                    ifid_flush   = 1'b1;
                    redirect     = 1'b1;
                    next_state   = ST_FLUSH;
                end else if (resume) begin
                    next_state = ST_RUN;
                end
            end
            default: begin
                if (!in_flow) begin
                    next_state = ST_RESET;
                end else if (exc_req || branch_taken || jump) begin
                    next_address = exc_req      ? EXC_VECTOR    :
                                   branch_taken ? branch_target : jump_target;
                    pc_write     = 1'b1;
                    ifid_flush   = 1'b1;
                    redirect     = 1'b1;
                    next_state   = ST_FLUSH;
                // FLUSH only honours redirects; stall/halt wait for RUN
                end else if (stall_req && state != ST_FLUSH) begin
                    next_state = ST_STALL;
                end else if (halt && state != ST_FLUSH) begin
                    next_state = ST_HALT;
                end else begin
                    next_address = address + ADDR_W'(PC_INC);
                    pc_write     = 1'b1;
                    ifid_write   = 1'b1;
                    next_state   = ST_RUN;
                end
            end
        endcase
    end

    sat_counter #(.WIDTH(8)) u_stall_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (state != ST_STALL),
        .inc   (state == ST_STALL),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(16)) u_redirect_count (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (redirect),
        .count (redirect_count)
    );

endmodule
